dvs_ravens_event_fifo: RTL and testbench

//  Single-port event queue between DVS capture (master M1, writer) and Ravens readout (master M2, reader).

---
 rtl/dvs_ravens_event_fifo.sv | 138 +++++++++++++
 tb/tb_dvs_ravens_event_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_ravens_event_fifo.sv
// dvs_ravens_event_fifo: event queue between the DVS capture stage (writer, M1) and the
// Ravens readout (reader, M2). A single storage port is shared by both grants.
//
// Handshake: grant_m1 and grant_m2 are single-cycle strobes from the arbiter. Each one is
// sampled on the rising clk edge, and there is no ready back to the arbiter. Instead,
// fifo_full and fifo_empty (both registered) act as the backpressure. A pop returns
// rd_data together with a one-cycle rd_valid pulse, one edge after the grant.
module dvs_ravens_event_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  grant_m1,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  grant_m2,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic [CNT_WIDTH-1:0]  count,
   input  logic                  err_clr,
   output logic                  err_overflow,
   output logic                  err_underflow,
   output logic                  err_collision
);

   localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  fifo_empty_q, fifo_empty_d;
   logic                  fifo_full_q, fifo_full_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  err_overflow_q, err_overflow_d;
   logic                  err_underflow_q, err_underflow_d;
   logic                  err_collision_q, err_collision_d;
   logic                  do_push, do_pop;

   // Qualify the grants, advance pointers with an explicit wrap, and build the next-state values.
   always_comb begin
      do_push = grant_m1 && !fifo_full_q;
      // A collision gives the write priority: the pop is dropped.
      do_pop  = grant_m2 && !fifo_empty_q && !grant_m1;

      wr_ptr_d = wr_ptr_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
      end

      rd_ptr_d = rd_ptr_q;
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
      end

      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_WIDTH'(1);
      end

      // The flags follow the post-operation count, so the arbiter sees only flop outputs.
      fifo_empty_d = (count_d == '0);
      fifo_full_d  = (count_d == CNT_WIDTH'(DEPTH));

      rd_valid_d = do_pop;
      rd_data_d  = do_pop ? mem_q[rd_ptr_q] : rd_data_q;

      // Error flags are sticky. A clear wins over any error raised in the same cycle.
      // The pop dropped by a collision reports only the collision, not an underflow.
      if (err_clr) begin
         err_overflow_d  = 1'b0;
         err_underflow_d = 1'b0;
         err_collision_d = 1'b0;
      end else begin
         err_overflow_d  = err_overflow_q  || (grant_m1 && fifo_full_q);
         err_underflow_d = err_underflow_q || (grant_m2 && fifo_empty_q && !grant_m1);
         err_collision_d = err_collision_q || (grant_m1 && grant_m2);
      end
   end

   // Control and status state. An asynchronous reset discards every queued event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         fifo_empty_q    <= 1'b1;
         fifo_full_q     <= 1'b0;
         rd_data_q       <= '0;
         rd_valid_q      <= 1'b0;
         err_overflow_q  <= 1'b0;
         err_underflow_q <= 1'b0;
         err_collision_q <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         fifo_empty_q    <= fifo_empty_d;
         fifo_full_q     <= fifo_full_d;
         rd_data_q       <= rd_data_d;
         rd_valid_q      <= rd_valid_d;
         err_overflow_q  <= err_overflow_d;
         err_underflow_q <= err_underflow_d;
         err_collision_q <= err_collision_d;
      end
   end

   // Event storage. It is deliberately left unreset so it can map onto a RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign fifo_empty    = fifo_empty_q;
   assign fifo_full     = fifo_full_q;
   assign count         = count_q;
   assign err_overflow  = err_overflow_q;
   assign err_underflow = err_underflow_q;
   assign err_collision = err_collision_q;

   // Occupancy must match the pointer distance (except when full), and empty/full are exclusive.
   a_flags_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_empty_q && fifo_full_q));
   a_count_matches_ptrs : assert property (@(posedge clk) disable iff (!rst_n)
      fifo_full_q ||
      (((int'(wr_ptr_q) + DEPTH - int'(rd_ptr_q)) % DEPTH) == int'(count_q)));

endmodule

// File: tb/tb_dvs_ravens_event_fifo.sv
// Testbench for dvs_ravens_event_fifo: directed vectors. The driver keeps a reference queue and
// pushes the expected pop data into exp_q. A negedge monitor checks every rd_valid against it.
module tb_dvs_ravens_event_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          grant_m1;
  logic [W-1:0]  wr_data;
  logic          grant_m2;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] count;
  logic          err_clr;
  logic          err_overflow;
  logic          err_underflow;
  logic          err_collision;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];   // expected rd_data, in order
  logic [W-1:0] mdl_q[$];   // reference contents of the FIFO
  logic [W-1:0] last_rd;    // value rd_data must hold between pops

  dvs_ravens_event_fifo #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .grant_m1(grant_m1), .wr_data(wr_data), .grant_m2(grant_m2),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .count(count),
    .err_clr(err_clr), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_collision(err_collision)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got rd_valid with rd_data=%h, required no read", rd_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL sb_rd_data: got %h, required %h", rd_data, e);
        end
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mdl_q.size()));
    chk({tag, "_empty"}, 32'(fifo_empty), 32'(mdl_q.size() == 0));
    chk({tag, "_full"},  32'(fifo_full),  32'(mdl_q.size() == DEPTH));
  endtask

  task automatic chk_errs(input string tag, input logic ov, input logic un, input logic co);
    chk({tag, "_err_overflow"},  32'(err_overflow),  32'(ov));
    chk({tag, "_err_underflow"}, 32'(err_underflow), 32'(un));
    chk({tag, "_err_collision"}, 32'(err_collision), 32'(co));
  endtask

  // ---------------- driver ----------------
  // Called at a negedge. Drives one cycle of grants and returns at the following negedge,
  // when the registered outputs already show the effect of the operation.
  task automatic do_op(input logic g1, input logic g2, input logic [W-1:0] d, input logic clr);
    logic pop_exp;
    pop_exp  = g2 && !g1 && (mdl_q.size() > 0);
    grant_m1 = g1;
    grant_m2 = g2;
    wr_data  = d;
    err_clr  = clr;
    if (g1 && mdl_q.size() < DEPTH) mdl_q.push_back(d);
    if (pop_exp) begin
      last_rd = mdl_q.pop_front();
      exp_q.push_back(last_rd);
    end
    @(negedge clk);
    grant_m1 = 1'b0;
    grant_m2 = 1'b0;
    err_clr  = 1'b0;
    chk("rd_valid_latency", 32'(rd_valid), 32'(pop_exp));
    if (!pop_exp) chk("rd_data_hold", 32'(rd_data), 32'(last_rd));
  endtask

  task automatic push(input logic [W-1:0] d);
    do_op(1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic pop();
    do_op(1'b0, 1'b1, '0, 1'b0);
  endtask

  task automatic idle();
    do_op(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Mixed directed vectors: {grant_m1, grant_m2, wr_data}
  localparam int NV = 10;
  logic [W+1:0] vec [NV] = '{
    {2'b10, 16'hA001}, {2'b10, 16'hA002}, {2'b01, 16'h0000}, {2'b10, 16'hA003},
    {2'b01, 16'h0000}, {2'b10, 16'hA004}, {2'b10, 16'hA005}, {2'b01, 16'h0000},
    {2'b01, 16'h0000}, {2'b01, 16'h0000}
  };

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; grant_m1 = 1'b0; grant_m2 = 1'b0; wr_data = '0; err_clr = 1'b0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    chk_state("reset");
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk_errs("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: an asynchronous reset mid-stream, with count=5 and rd_valid high.
    // A prior underflow leaves an error flag set, so the reset has to clear it.
    pop();
    chk("t1_pre_underflow", 32'(err_underflow), 32'h1);
    for (int i = 0; i < 6; i++) push(16'h1100 + 16'(i));
    pop();
    chk("t1_pre_count", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_count", 32'(count), 32'h0);
    chk("t1_empty", 32'(fifo_empty), 32'h1);
    chk("t1_full", 32'(fifo_full), 32'h0);
    chk("t1_rd_valid", 32'(rd_valid), 32'h0);
    chk_errs("t1", 1'b0, 1'b0, 1'b0);
    mdl_q.delete();
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T2: ordering
    for (int i = 1; i <= 4; i++) push(16'(i));
    chk_state("t2_loaded");
    for (int i = 0; i < 4; i++) pop();
    chk_state("t2_drained");

    // T3: fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) push(16'h3000 + 16'(i));
    chk("t3_full", 32'(fifo_full), 32'h1);
    chk("t3_count", 32'(count), 32'd16);
    push(16'hBEEF);
    chk("t3_overflow", 32'(err_overflow), 32'h1);
    chk("t3_count_after_drop", 32'(count), 32'd16);
    pop();
    chk("t3_full_drops", 32'(fifo_full), 32'h0);
    for (int i = 1; i < DEPTH; i++) pop();
    chk_state("t3_drained");
    do_op(1'b0, 1'b0, '0, 1'b1);
    chk_errs("t3_clr", 1'b0, 1'b0, 1'b0);

    // T4: pointer wrap
    for (int i = 0; i < 12; i++) push(16'(i));
    for (int i = 0; i < 12; i++) pop();
    for (int i = 12; i < 24; i++) push(16'(i));
    chk_state("t4_mid");
    for (int i = 0; i < 12; i++) pop();
    chk("t4_count_zero", 32'(count), 32'h0);

    // T5: underflow, then a collision at count=3, then an error clear
    pop();
    chk_errs("t5_underflow", 1'b0, 1'b1, 1'b0);
    do_op(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) push(16'h5500 + 16'(i));
    do_op(1'b1, 1'b1, 16'h55C4, 1'b0);
    chk("t5_coll_count", 32'(count), 32'd4);
    chk_errs("t5_collision", 1'b0, 1'b0, 1'b1);
    do_op(1'b0, 1'b0, '0, 1'b1);
    chk_errs("t5_clr", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop();
    chk_state("t5_drained");
    // A clear outranks an underflow raised in the same cycle.
    do_op(1'b0, 1'b1, '0, 1'b1);
    chk_errs("t5_clr_priority", 1'b0, 1'b0, 1'b0);

    // Mixed interleaved pushes and pops
    for (int i = 0; i < NV; i++) begin
      logic [W+1:0] v;
      v = vec[i];
      do_op(v[W+1], v[W], v[W-1:0], 1'b0);
    end
    chk_state("mixed_end");
    chk_errs("mixed_end", 1'b0, 1'b0, 1'b0);

    idle();
    idle();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
